// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: opcodes, control-bit positions,
// read-enable positions and the decode-stage halt sequencer states.
package cpu_pkg;

  localparam int CTRL_W = 7;
  localparam int RD_W   = 2;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_PADDSB = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_AND    = 4'h3;
  localparam logic [3:0] OP_NOR    = 4'h4;
  localparam logic [3:0] OP_SLL    = 4'h5;
  localparam logic [3:0] OP_SRL    = 4'h6;
  localparam logic [3:0] OP_SRA    = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_JAL    = 4'hD;
  localparam logic [3:0] OP_JR     = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int CB_HALT     = 0;
  localparam int CB_REGWRITE = 1;
  localparam int CB_MEMTOREG = 2;
  localparam int CB_MEMWRITE = 3;
  localparam int CB_MEMREAD  = 4;
  localparam int CB_BRANCH   = 5;
  localparam int CB_ALUSRC   = 6;

  localparam int RE0 = 0;
  localparam int RE1 = 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/opcode_decode.sv
// Pure combinational opcode table: 4-bit opcode to control bits and
// register read-port enables.
module opcode_decode
  import cpu_pkg::*;
(
  input  logic [3:0]        opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RD_W-1:0]   read
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    ctrl = '0;
    read = '0;
    unique case (opcode)
      OP_ADD, OP_PADDSB, OP_SUB, OP_AND, OP_NOR: begin
        ctrl[CB_REGWRITE] = 1'b1;
        read              = 2'b11;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_LHB: begin
        ctrl[CB_ALUSRC]   = 1'b1;
        ctrl[CB_REGWRITE] = 1'b1;
        read[RE0]         = 1'b1;
      end
      OP_LW: begin
        ctrl[CB_ALUSRC]   = 1'b1;
        ctrl[CB_MEMREAD]  = 1'b1;
        ctrl[CB_MEMTOREG] = 1'b1;
        ctrl[CB_REGWRITE] = 1'b1;
        read[RE1]         = 1'b1;
      end
      OP_SW: begin
        ctrl[CB_ALUSRC]   = 1'b1;
        ctrl[CB_MEMWRITE] = 1'b1;
        read              = 2'b11;
      end
      OP_LLB: begin
        ctrl[CB_ALUSRC]   = 1'b1;
        ctrl[CB_REGWRITE] = 1'b1;
      end
      OP_B: begin
        ctrl[CB_BRANCH] = 1'b1;
      end
      OP_JAL: begin
        ctrl[CB_REGWRITE] = 1'b1;
      end
      OP_JR: begin
        ctrl[CB_BRANCH] = 1'b1;
        read[RE1]       = 1'b1;
      end
      OP_HLT: begin
        ctrl[CB_HALT] = 1'b1;
      end
      default: begin
        ctrl = '0;
        read = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_decode_ctrl.sv
// ID stage control: decode, load-use hazard stall, flush squash, ID/EX
// registers and the HLT drain sequencer. Optional stall counter under
// PIPE_DECODE_STALL_CNT_EN.
module pipe_decode_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W     = 4,
  parameter int DRAIN_CYC = 3,
  parameter int ZERO_REG  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [3:0]        opcode,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              flush,
  output logic              stall_out,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [RD_W-1:0]   read_q,
  output logic              valid_q,
  output logic              halted
`ifdef PIPE_DECODE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [REG_W-1:0] ZERO_IDX   = REG_W'(ZERO_REG);
  localparam logic [3:0]       DRAIN_INIT = 4'(DRAIN_CYC - 1);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [RD_W-1:0]   dec_read;
  logic              haz;
  logic              run;
  logic              bubble;
  logic              hlt_load;
  state_t            state;
  logic [3:0]        drain_cnt;

  opcode_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec_ctrl),
    .read   (dec_read)
  );

  // Load-use: only ports the instruction actually reads can collide with the load.
  assign haz = instr_valid & ex_mem_read & (ex_rd != ZERO_IDX) &
               ((dec_read[RE0] & (rs == ex_rd)) | (dec_read[RE1] & (rt == ex_rd)));

  assign run       = (state == RUN);
  assign stall_out = (haz & ~flush) | ~run;
  assign bubble    = flush | haz | ~instr_valid | ~run;
  assign hlt_load  = ~bubble & (opcode == OP_HLT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      read_q    <= '0;
      valid_q   <= 1'b0;
      halted    <= 1'b0;
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      if (bubble) begin
        ctrl_q  <= '0;
        read_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        ctrl_q  <= dec_ctrl;
        read_q  <= dec_read;
        valid_q <= 1'b1;
      end

      unique case (state)
        RUN: begin
          if (hlt_load) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_DECODE_STALL_CNT_EN
  // Counts only genuine hazard stalls, not drain/halt stalls or squashed ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (haz & ~flush & run & (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Scoreboard bench for pipe_decode_ctrl: directed vectors push expected
// ID/EX register contents; a monitor pops and compares after each edge.
module tb_pipe_decode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [3:0] opcode;
  logic [3:0] rs;
  logic [3:0] rt;
  logic       ex_mem_read;
  logic [3:0] ex_rd;
  logic       flush;
  logic       stall_out;
  logic [6:0] ctrl_q;
  logic [1:0] read_q;
  logic       valid_q;
  logic       halted;
`ifdef PIPE_DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  typedef struct {
    logic [6:0] ctrl;
    logic [1:0] rd;
    logic       vld;
    logic       hlt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_decode_ctrl #(.REG_W(4), .DRAIN_CYC(3), .ZERO_REG(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .flush       (flush),
    .stall_out   (stall_out),
    .ctrl_q      (ctrl_q),
    .read_q      (read_q),
    .valid_q     (valid_q),
    .halted      (halted)
`ifdef PIPE_DECODE_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] s,
                       input logic [3:0] t, input logic mr, input logic [3:0] erd,
                       input logic fl);
    instr_valid = v;
    opcode      = op;
    rs          = s;
    rt          = t;
    ex_mem_read = mr;
    ex_rd       = erd;
    flush       = fl;
  endtask

  // One cycle: drive on the falling edge, check the combinational stall,
  // queue what the registers must hold after the next rising edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [3:0] s,
                      input logic [3:0] t, input logic mr, input logic [3:0] erd,
                      input logic fl, input logic [6:0] ec, input logic [1:0] er,
                      input logic ev, input logic es, input logic eh);
    exp_t e;
    @(negedge clk);
    drive(v, op, s, t, mr, erd, fl);
    #1;
    check("stall_out", {31'd0, stall_out}, {31'd0, es});
    e.ctrl = ec;
    e.rd   = er;
    e.vld  = ev;
    e.hlt  = eh;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctrl_q",  {25'd0, ctrl_q},  {25'd0, e.ctrl});
        check("read_q",  {30'd0, read_q},  {30'd0, e.rd});
        check("valid_q", {31'd0, valid_q}, {31'd0, e.vld});
        check("halted",  {31'd0, halted},  {31'd0, e.hlt});
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    #3;
    check("rst_ctrl_q",    {25'd0, ctrl_q},    32'h0);
    check("rst_read_q",    {30'd0, read_q},    32'h0);
    check("rst_valid_q",   {31'd0, valid_q},   32'h0);
    check("rst_halted",    {31'd0, halted},    32'h0);
    check("rst_stall_out", {31'd0, stall_out}, 32'h0);
`ifdef PIPE_DECODE_STALL_CNT_EN
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'h0);
`endif
    #9 rst = 1'b0;

    //   v    op     rs     rt     mr    erd    fl    ctrl   read   vld   stall hlt
    step(1'b1, 4'h8, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h56, 2'b10, 1'b1, 1'b0, 1'b0); // LW
    step(1'b1, 4'h0, 4'h3, 4'h4, 1'b1, 4'h3, 1'b0, 7'h00, 2'b00, 1'b0, 1'b1, 1'b0); // ADD rs hazard
    step(1'b1, 4'h0, 4'h3, 4'h4, 1'b0, 4'h3, 1'b0, 7'h02, 2'b11, 1'b1, 1'b0, 1'b0); // ADD released
    step(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 7'h02, 2'b11, 1'b1, 1'b0, 1'b0); // zero reg
    step(1'b1, 4'h5, 4'h1, 4'h5, 1'b1, 4'h5, 1'b0, 7'h42, 2'b01, 1'b1, 1'b0, 1'b0); // SLL rt unread
    step(1'b1, 4'h9, 4'h1, 4'h6, 1'b1, 4'h6, 1'b0, 7'h00, 2'b00, 1'b0, 1'b1, 1'b0); // SW rt hazard
    step(1'b1, 4'h0, 4'h3, 4'h4, 1'b1, 4'h3, 1'b1, 7'h00, 2'b00, 1'b0, 1'b0, 1'b0); // flush + haz
`ifdef PIPE_DECODE_STALL_CNT_EN
    @(posedge clk);
    #2;
    check("stall_cnt_after_flush", {16'd0, stall_cnt}, 32'd2);
`endif
    step(1'b0, 4'h2, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h00, 2'b00, 1'b0, 1'b0, 1'b0); // not valid
    step(1'b1, 4'hE, 4'h7, 4'h2, 1'b0, 4'h0, 1'b0, 7'h20, 2'b10, 1'b1, 1'b0, 1'b0); // JR
    step(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, 7'h00, 2'b00, 1'b0, 1'b0, 1'b0); // HLT flushed
    step(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h02, 2'b11, 1'b1, 1'b0, 1'b0); // still RUN
    step(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 7'h01, 2'b00, 1'b1, 1'b0, 1'b0); // HLT loads
    step(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b1, 7'h00, 2'b00, 1'b0, 1'b1, 1'b0); // drain 1
    step(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h00, 2'b00, 1'b0, 1'b1, 1'b0); // drain 2
    step(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h00, 2'b00, 1'b0, 1'b1, 1'b1); // drain 3
    step(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h00, 2'b00, 1'b0, 1'b1, 1'b1); // halted
    step(1'b1, 4'h8, 4'h1, 4'h2, 1'b0, 4'h0, 1'b1, 7'h00, 2'b00, 1'b0, 1'b1, 1'b1); // halted

    // Reset out of HALTED, asserted between clock edges.
    @(posedge clk);
    #3;
    drive(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    #1;
    check("halted_after_rst", {31'd0, halted},    32'h0);
    check("stall_after_rst",  {31'd0, stall_out}, 32'h0);
`ifdef PIPE_DECODE_STALL_CNT_EN
    check("stall_cnt_after_rst", {16'd0, stall_cnt}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 7'h01, 2'b00, 1'b1, 1'b0, 1'b0); // HLT loads

    // Reset in the first DRAIN cycle, while ctrl_q still holds the HLT.
    @(posedge clk);
    #3;
    drive(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0);
    rst = 1'b1;
    #1;
    check("middrain_ctrl_q",  {25'd0, ctrl_q},    32'h0);
    check("middrain_valid_q", {31'd0, valid_q},   32'h0);
    check("middrain_halted",  {31'd0, halted},    32'h0);
    check("middrain_stall",   {31'd0, stall_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h02, 2'b11, 1'b1, 1'b0, 1'b0); // back in RUN
    step(1'b1, 4'hB, 4'h1, 4'h2, 1'b1, 4'h1, 1'b0, 7'h42, 2'b00, 1'b1, 1'b0, 1'b0); // LLB no reads
    step(1'b0, 4'h0, 4'h1, 4'h2, 1'b0, 4'h0, 1'b0, 7'h00, 2'b00, 1'b0, 1'b0, 1'b0); // idle

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 32'd0);

`ifdef PIPE_DECODE_STALL_CNT_EN
    @(negedge clk);
    drive(1'b1, 4'h0, 4'h3, 4'h4, 1'b1, 4'h3, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    check("stall_cnt_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
    check("stall_during_sat",    {31'd0, stall_out}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
